preadd_mult_sched: RTL and testbench

PREADD_MULT_SCHED -- requirements
Module: preadd_mult_sched

---
 rtl/preadd_mult_sched.sv | 160 ++++++++++++++++
 tb/tb_preadd_mult_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/preadd_mult_sched.sv
// -----------------------------------------------------------------------------
// preadd_mult_sched
//
// Purpose:
//   Round-robin scheduler that feeds a shared external pre-adder multiplier
//   ((a +/- d) * b) from NREQ requesters. It travels a {valid, id} tag through
//   a LAT-deep shift register alongside the multiplier pipeline, so each
//   product leaves with the id of the requester that issued it. A stalled
//   output (res_valid && !res_ready) freezes the multiplier and the tags.
//
// Configuration:
//   PREADD_SCHED_PRIO0_EN - when defined, requester 0 wins whenever it is
//                           valid. The other requesters share round-robin
//                           among themselves. When undefined, all requesters
//                           are pure round-robin.
//
// Ports:
//   clk, rst_n       rising-edge clock, synchronous active-low reset
//   req_valid/ready  per-requester request and one-hot (or zero) grant
//   req_subadd       per-requester op select (1 = a-d, 0 = a+d)
//   req_a/d/b        packed signed operands; requester i at [i*W +: W]
//   m_rst, m_ce      multiplier reset and clock enable
//   m_subadd, m_ain, m_din, m_bin
//                    operands of the granted requester (zero with no grant)
//   m_pout           multiplier product
//   res_valid/ready  result handshake
//   res_data, res_id product and owning requester
//   in_flight        number of valid tags in the pipeline
// -----------------------------------------------------------------------------
module preadd_mult_sched #(
    parameter int NREQ = 4,
    parameter int AW   = 16,
    parameter int BW   = 18,
    parameter int MW   = AW + 1 + BW,
    parameter int LAT  = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_subadd,
    input  logic [NREQ*AW-1:0]   req_a,
    input  logic [NREQ*AW-1:0]   req_d,
    input  logic [NREQ*BW-1:0]   req_b,
    output logic                 m_rst,
    output logic                 m_ce,
    output logic                 m_subadd,
    output logic [AW-1:0]        m_ain,
    output logic [AW-1:0]        m_din,
    output logic [BW-1:0]        m_bin,
    input  logic [MW-1:0]        m_pout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [MW-1:0]        res_data,
    output logic [IW-1:0]        res_id,
    output logic [2:0]           in_flight
);

`ifdef PREADD_SCHED_PRIO0_EN
    localparam bit Prio0En = 1'b1;
`else
    localparam bit Prio0En = 1'b0;
`endif

    logic [IW-1:0]          lastGrant_q;
    logic [IW-1:0]          lastGrant_d;
    logic [LAT-1:0]         tagValid_q;
    logic [LAT-1:0][IW-1:0] tagId_q;
    logic                   grantAny;
    logic [IW-1:0]          grantId;
    logic [2:0]             flightCount;
    int                     rrCand;

    // The multiplier is an external pipeline with no enable of its own
    // beyond m_ce. Freezing it on an output stall keeps the product and the
    // tag at the last stage aligned and holding.
    assign m_rst     = !rst_n;
    assign res_valid = rst_n && tagValid_q[LAT-1];
    assign res_id    = tagId_q[LAT-1];
    assign res_data  = m_pout;
    assign m_ce      = !(res_valid && !res_ready);

    // Arbitration. The search begins one past the previous winner, so each
    // requester gets at most one grant per full rotation. In priority mode
    // requester 0 short-circuits the search. It is also skipped by the
    // rotating search, so the others keep their own fairness order.
    always_comb begin
        grantAny    = 1'b0;
        grantId     = '0;
        rrCand      = 0;
        lastGrant_d = lastGrant_q;
        if (rst_n && m_ce && (|req_valid)) begin
            if (Prio0En && req_valid[0]) begin
                grantAny = 1'b1;
                grantId  = '0;
            end else begin
                for (int off = 1; off <= NREQ; off++) begin
                    rrCand = (int'(lastGrant_q) + off) % NREQ;
                    if (!grantAny && req_valid[rrCand] && !(Prio0En && rrCand == 0)) begin
                        grantAny = 1'b1;
                        grantId  = IW'(rrCand);
                    end
                end
            end
        end
        // A priority win by requester 0 must not disturb the rotation of
        // the others, so it leaves the pointer alone.
        if (grantAny && !(Prio0En && grantId == '0)) begin
            lastGrant_d = grantId;
        end
    end

    // Grant vector and operand muxes. With no grant the multiplier sees
    // zeros, so an idle bubble carries no stale requester data.
    always_comb begin
        req_ready = '0;
        m_subadd  = 1'b0;
        m_ain     = '0;
        m_din     = '0;
        m_bin     = '0;
        if (grantAny) begin
            req_ready = NREQ'(1) << grantId;
            m_subadd  = req_subadd[grantId];
            m_ain     = req_a[int'(grantId)*AW +: AW];
            m_din     = req_d[int'(grantId)*AW +: AW];
            m_bin     = req_b[int'(grantId)*BW +: BW];
        end
    end

    // Occupancy is the number of valid tags. It reads zero during reset so
    // the reset cycle already looks empty from outside.
    always_comb begin
        flightCount = 3'd0;
        for (int i = 0; i < LAT; i++) begin
            if (tagValid_q[i]) begin
                flightCount = flightCount + 3'd1;
            end
        end
        in_flight = rst_n ? flightCount : 3'd0;
    end

    // Tag pipeline and arbitration pointer. Reset drops every in-flight
    // tag, so products for pre-reset requests never surface. It also parks
    // the pointer on the last requester so requester 0 is served first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tagValid_q  <= '0;
            tagId_q     <= '0;
            lastGrant_q <= IW'(NREQ - 1);
        end else begin
            lastGrant_q <= lastGrant_d;
            if (m_ce) begin
                tagValid_q <= {tagValid_q[LAT-2:0], grantAny};
                tagId_q    <= {tagId_q[LAT-2:0], grantId};
            end
        end
    end

endmodule

// File: tb/tb_preadd_mult_sched.sv
// -----------------------------------------------------------------------------
// tb_preadd_mult_sched
//
// Purpose:
//   Self-checking bench for preadd_mult_sched. It contains:
//   - a behavioural model of the external multiplier (LAT ce-qualified stages);
//   - a scoreboard that predicts grants, stalls, occupancy and results from
//     queues of outstanding operations;
//   - directed scenarios with literal expectations, then randomized traffic.
//   Honors PREADD_SCHED_PRIO0_EN for the priority scenario.
// -----------------------------------------------------------------------------
module tb_preadd_mult_sched;

    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int BW   = 18;
    localparam int MW   = AW + 1 + BW;
    localparam int LAT  = 4;
    localparam int IW   = $clog2(NREQ);

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_subadd;
    logic [NREQ*AW-1:0]   req_a;
    logic [NREQ*AW-1:0]   req_d;
    logic [NREQ*BW-1:0]   req_b;
    logic                 m_rst;
    logic                 m_ce;
    logic                 m_subadd;
    logic [AW-1:0]        m_ain;
    logic [AW-1:0]        m_din;
    logic [BW-1:0]        m_bin;
    logic [MW-1:0]        m_pout;
    logic                 res_valid;
    logic                 res_ready;
    logic [MW-1:0]        res_data;
    logic [IW-1:0]        res_id;
    logic [2:0]           in_flight;

    int checks;
    int errors;

    logic signed [AW-1:0] opA [NREQ];
    logic signed [AW-1:0] opD [NREQ];
    logic signed [BW-1:0] opB [NREQ];
    logic                 opSub [NREQ];

    preadd_mult_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_subadd (req_subadd),
        .req_a      (req_a),
        .req_d      (req_d),
        .req_b      (req_b),
        .m_rst      (m_rst),
        .m_ce       (m_ce),
        .m_subadd   (m_subadd),
        .m_ain      (m_ain),
        .m_din      (m_din),
        .m_bin      (m_bin),
        .m_pout     (m_pout),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .in_flight  (in_flight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full-width signed (a +/- d) * b, truncated to the product width.
    function automatic logic [MW-1:0] prodOf(input logic signed [AW-1:0] a,
                                             input logic signed [AW-1:0] d,
                                             input logic signed [BW-1:0] b,
                                             input logic sub);
        longint s;
        longint p;
        s = sub ? (longint'(a) - longint'(d)) : (longint'(a) + longint'(d));
        p = s * longint'(b);
        return p[MW-1:0];
    endfunction

    // External multiplier: LAT stages, advancing only on m_ce.
    logic [MW-1:0] multPipe [LAT];
    always @(posedge clk) begin
        if (m_rst) begin
            for (int i = 0; i < LAT; i++) multPipe[i] <= '0;
        end else if (m_ce) begin
            multPipe[0] <= prodOf(m_ain, m_din, m_bin, m_subadd);
            for (int i = 1; i < LAT; i++) multPipe[i] <= multPipe[i-1];
        end
    end
    assign m_pout = multPipe[LAT-1];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ohIdx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Scoreboard state: outstanding operations in issue order. Each entry
    // has an age in ce-qualified edges; age LAT means it is at the output.
    int            qId [$];
    logic [MW-1:0] qData [$];
    int            qAge [$];
    int            modelLast;

    function automatic int expGrant(input logic ce);
        int c;
        if (!(rst_n && ce)) return -1;
`ifdef PREADD_SCHED_PRIO0_EN
        if (req_valid[0]) return 0;
`endif
        for (int off = 1; off <= NREQ; off++) begin
            c = (modelLast + off) % NREQ;
`ifdef PREADD_SCHED_PRIO0_EN
            if (c != 0 && req_valid[c]) return c;
`else
            if (req_valid[c]) return c;
`endif
        end
        return -1;
    endfunction

    // Compare process: predicts every output for the current cycle, checks
    // it, then advances the model as the coming clock edge will.
    initial begin
        int   g;
        logic rvExp;
        logic ceExp;
        modelLast = NREQ - 1;
        forever begin
            @(negedge clk);
            rvExp = rst_n && (qAge.size() > 0) && (qAge[0] == LAT);
            ceExp = !(rvExp && !res_ready);
            g     = expGrant(ceExp);
            checkOutput("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
            checkOutput("m_ce", m_ce, ceExp);
            checkOutput("m_rst", m_rst, !rst_n);
            checkOutput("res_valid", res_valid, rvExp);
            checkOutput("in_flight", in_flight, rst_n ? qAge.size() : 0);
            if (rvExp) begin
                checkOutput("res_id", res_id, qId[0]);
                checkOutput("res_data", res_data, qData[0]);
            end
            if (g >= 0) begin
                checkOutput("m_ain", m_ain, req_a[g*AW +: AW]);
                checkOutput("m_din", m_din, req_d[g*AW +: AW]);
                checkOutput("m_bin", m_bin, req_b[g*BW +: BW]);
                checkOutput("m_subadd", m_subadd, req_subadd[g]);
            end else begin
                checkOutput("m_idle_ops", {m_subadd, m_ain, m_din, m_bin}, 0);
            end
            if (!rst_n) begin
                qId.delete();
                qData.delete();
                qAge.delete();
                modelLast = NREQ - 1;
            end else if (ceExp) begin
                if (rvExp) begin
                    void'(qId.pop_front());
                    void'(qData.pop_front());
                    void'(qAge.pop_front());
                end
                foreach (qAge[i]) qAge[i] = qAge[i] + 1;
                if (g >= 0) begin
                    qId.push_back(g);
                    qData.push_back(prodOf(req_a[g*AW +: AW], req_d[g*AW +: AW],
                                           req_b[g*BW +: BW], req_subadd[g]));
                    qAge.push_back(1);
`ifdef PREADD_SCHED_PRIO0_EN
                    if (g != 0) modelLast = g;
`else
                    modelLast = g;
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ready);
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*AW +: AW]  = opA[i];
            req_d[i*AW +: AW]  = opD[i];
            req_b[i*BW +: BW]  = opB[i];
            req_subadd[i]      = opSub[i];
        end
        req_valid = valid;
        res_ready = ready;
    endtask

    task automatic randomOps();
        for (int i = 0; i < NREQ; i++) begin
            opA[i]   = AW'($urandom());
            opD[i]   = AW'($urandom());
            opB[i]   = BW'($urandom());
            opSub[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for res_valid; lat counts cycles after the grant cycle.
    task automatic waitResult(output int lat);
        lat = 1;
        while (lat < 12) begin
            @(negedge clk);
            if (res_valid) break;
            tick();
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   lat;
        int   cnt;
        logic [MW-1:0] held;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = '0; opD[i] = '0; opB[i] = '0; opSub[i] = 1'b0;
        end
        applyStimulus('0, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;

        $display("[TB] single request, add");
        opA[0] = 16'sd100; opD[0] = -16'sd20; opB[0] = 18'sd3; opSub[0] = 1'b0;
        applyStimulus(4'b0001, 1'b1);
        @(negedge clk);
        checkOutput("single_grant", req_ready, 4'b0001);
        tick();
        applyStimulus('0, 1'b1);
        waitResult(lat);
        checkOutput("single_latency", lat, 4);
        checkOutput("single_data", res_data, 240);
        checkOutput("single_id", res_id, 0);
        tick();

        $display("[TB] single request, subtract");
        opA[2] = 16'sd100; opD[2] = -16'sd20; opB[2] = 18'sd3; opSub[2] = 1'b1;
        applyStimulus(4'b0100, 1'b1);
        @(negedge clk);
        checkOutput("sub_grant", req_ready, 4'b0100);
        tick();
        applyStimulus('0, 1'b1);
        waitResult(lat);
        checkOutput("sub_latency", lat, 4);
        checkOutput("sub_data", res_data, 360);
        checkOutput("sub_id", res_id, 2);
        tick();

        $display("[TB] all requesters valid");
        doReset();
        randomOps();
        applyStimulus(4'hF, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("rr_grant", ohIdx(req_ready), i % 4);
            if (i >= 4) begin
                checkOutput("rr_res_valid", res_valid, 1);
                checkOutput("rr_res_id", res_id, i - 4);
            end
            tick();
        end

        $display("[TB] backpressure");
        applyStimulus(4'hF, 1'b0);
        held = '0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (j == 0) held = res_data;
            checkOutput("stall_ce", m_ce, 0);
            checkOutput("stall_ready", req_ready, 0);
            checkOutput("stall_in_flight", in_flight, 4);
            checkOutput("stall_hold", res_data, held);
            tick();
        end
        applyStimulus('0, 1'b1);
        cnt = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (res_valid) cnt++;
            tick();
        end
        checkOutput("drain_count", cnt, 4);

        $display("[TB] reset mid-operation");
        doReset();
        applyStimulus(4'hF, 1'b1);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_in_flight", in_flight, 0);
        checkOutput("rst_ready", req_ready, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_grant", ohIdx(req_ready), 0);
        tick();
        applyStimulus('0, 1'b1);
        cnt = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (res_valid) cnt++;
            tick();
        end
        checkOutput("post_rst_results", cnt, 1);

        $display("[TB] requesters 0 and 2");
        doReset();
        applyStimulus(4'b0101, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef PREADD_SCHED_PRIO0_EN
            checkOutput("prio_grant", ohIdx(req_ready), 0);
`else
            checkOutput("alt_grant", ohIdx(req_ready), (i % 2) * 2);
`endif
            tick();
        end
        applyStimulus('0, 1'b1);
        repeat (6) tick();

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            randomOps();
            rst_n = ($urandom_range(0, 99) != 0);
            applyStimulus(NREQ'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            tick();
        end
        rst_n = 1'b1;
        applyStimulus('0, 1'b1);
        repeat (10) tick();
        @(negedge clk);
        checkOutput("final_empty", in_flight, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
